seq_mult_n: RTL and testbench

- Parametrised sequential add-shift multiplier: one partial-product add and one shift per clock.
- Multiplies two WIDTH-bit operands and produces a 2*WIDTH-bit product.
- Mode input selects signed (two's complement, last step subtracts) or unsigned operation.
- Sits between operand switches/registers and hex display logic; it is the general successor to the fixed 8-bit lab multiplier datapath.

---
 rtl/mult_pkg.sv | 7 +
 rtl/add_sub_n.sv | 19 +
 rtl/full_adder.sv | 11 +
 rtl/seq_mult_n.sv | 65 ++++++
 tb/tb_seq_mult_n.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM state type and sizing helper for the sequential multiplier
package mult_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic int cnt_w(int w);
        return $clog2(w) + 1;
    endfunction
endpackage

// File: rtl/add_sub_n.sv
// add_sub_n: combinational ripple adder/subtractor built from full_adder cells
module add_sub_n #(
    parameter int N = 9
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Sub,
    output logic [N-1:0] S
);
    logic [N-1:0] bx;
    logic [N-1:0] c;
    assign bx   = B ^ {N{Sub}};
    assign c[0] = Sub;
    for (genvar i = 0; i < N - 1; i++) begin : g_fa
        full_adder u_fa (.a(A[i]), .b(bx[i]), .cin(c[i]), .s(S[i]), .cout(c[i+1]));
    end
    // carry out of the top bit is never needed, so the MSB is a plain sum bit
    assign S[N-1] = A[N-1] ^ bx[N-1] ^ c[N-1];
endmodule

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/seq_mult_n.sv
// seq_mult_n: add-shift multiplier, one partial product per clock, signed or unsigned
module seq_mult_n
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Start,
    input  logic               Signed_mode,
    input  logic [WIDTH-1:0]   Multiplicand,
    input  logic [WIDTH-1:0]   Multiplier,
    output logic               Busy,
    output logic               Done,
    output logic [2*WIDTH-1:0] Product
);
    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    state_t state, state_d;
    logic [WIDTH-1:0] a_q, b_q, s_q, a_d, b_d;
    logic [CW-1:0] count;
    logic mode, last;
    logic [WIDTH:0] sum;
    assign last = count == LAST;
    // signed mode subtracts the multiplicand on the sign-bit step
    add_sub_n #(.N(WIDTH + 1)) u_add (
        .A({mode & a_q[WIDTH-1], a_q}),
        .B(b_q[0] ? {mode & s_q[WIDTH-1], s_q} : '0),
        .Sub(mode & last),
        .S(sum)
    );
    assign a_d  = sum[WIDTH:1];
    assign b_d  = {sum[0], b_q[WIDTH-1:1]};
    assign Busy = state != IDLE;
    assign Done = state == DONE;
    always_comb begin
        state_d = (state == IDLE) ? (Start ? RUN : IDLE) :
                  (state == RUN)  ? (last ? DONE : RUN)  : IDLE;
    end
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            count   <= '0;
            mode    <= 1'b0;
            Product <= '0;
        end else begin
            state <= state_d;
            if (state == IDLE && Start) begin
                s_q   <= Multiplicand;
                b_q   <= Multiplier;
                a_q   <= '0;
                count <= '0;
                mode  <= Signed_mode;
            end else if (state == RUN) begin
                a_q   <= a_d;
                b_q   <= b_d;
                count <= count + CW'(1);
                if (last) Product <= {a_d, b_d};
            end
        end
    end
endmodule

// File: tb/tb_seq_mult_n.sv
// tb_seq_mult_n: randomized self-checking bench for seq_mult_n at widths 8, 4 and 16
module tb_seq_mult_n;
    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    logic start = 1'b0;
    logic smode = 1'b0;
    logic [1:0] sel = 2'd0;
    logic [31:0] mcand = '0, mplier = '0;
    logic b8, d8, b4, d4, b16, d16;
    logic [15:0] p8;
    logic [7:0] p4;
    logic [31:0] p16;
    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    seq_mult_n #(.WIDTH(8)) u_w8 (
        .Clk(Clk), .Reset_n(Reset_n), .Start(start && sel == 2'd0), .Signed_mode(smode),
        .Multiplicand(mcand[7:0]), .Multiplier(mplier[7:0]), .Busy(b8), .Done(d8), .Product(p8));
    seq_mult_n #(.WIDTH(4)) u_w4 (
        .Clk(Clk), .Reset_n(Reset_n), .Start(start && sel == 2'd1), .Signed_mode(smode),
        .Multiplicand(mcand[3:0]), .Multiplier(mplier[3:0]), .Busy(b4), .Done(d4), .Product(p4));
    seq_mult_n #(.WIDTH(16)) u_w16 (
        .Clk(Clk), .Reset_n(Reset_n), .Start(start && sel == 2'd2), .Signed_mode(smode),
        .Multiplicand(mcand[15:0]), .Multiplier(mplier[15:0]), .Busy(b16), .Done(d16), .Product(p16));

    logic busy_s, done_s;
    logic [63:0] prod_s;
    assign busy_s = sel == 2'd0 ? b8 : sel == 2'd1 ? b4 : b16;
    assign done_s = sel == 2'd0 ? d8 : sel == 2'd1 ? d4 : d16;
    assign prod_s = sel == 2'd0 ? 64'(p8) : sel == 2'd1 ? 64'(p4) : 64'(p16);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int width_of(input logic [1:0] s);
        return s == 2'd0 ? 8 : s == 2'd1 ? 4 : 16;
    endfunction

    // true mathematical product of the w-bit operands, reduced to 2w bits
    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic m, input int w);
        longint x, y, p;
        x = longint'(a) & ((longint'(1) << w) - 1);
        y = longint'(b) & ((longint'(1) << w) - 1);
        if (m && x[w-1]) x = x - (longint'(1) << w);
        if (m && y[w-1]) y = y - (longint'(1) << w);
        p = x * y;
        return 64'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    task automatic run_op(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b,
                          input logic m, input string tag);
        int w, done_n, busy_n;
        logic [63:0] exp;
        w = width_of(s);
        exp = ref_prod(a, b, m, w);
        sel = s; mcand = a; mplier = b; smode = m; start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        done_n = 0;
        busy_n = 0;
        for (int n = 1; n <= 3 * w && done_n == 0; n++) begin
            mcand = $urandom; mplier = $urandom; smode = 1'($urandom);
            if (busy_s) busy_n++;
            if (done_s) done_n = n;
            else begin
                @(posedge Clk); #1;
            end
        end
        check({tag, "_lat"}, 64'(done_n), 64'(w + 1));
        check({tag, "_busy"}, 64'(busy_n), 64'(w + 1));
        check({tag, "_prod"}, prod_s, exp);
        @(posedge Clk); #1;
        check({tag, "_idle"}, {62'd0, busy_s, done_s}, 64'd0);
        check({tag, "_hold"}, prod_s, exp);
    endtask

    initial begin
        logic [63:0] q[$];
        logic [63:0] exp;
        int last_done;
        int seen;
        #12;
        check("rst_state", {45'd0, b8, d8, p8}, 64'd0);
        check("rst_w16", {29'd0, b16, d16, p16}, 64'd0);
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        run_op(2'd0, 32'd7, 32'hC5, 1'b1, "s7xm59");
        run_op(2'd0, 32'h80, 32'h80, 1'b1, "sminxmin");
        run_op(2'd0, 32'hFF, 32'hFF, 1'b1, "sm1xm1");
        run_op(2'd0, 32'hFF, 32'hFF, 1'b0, "u255x255");
        run_op(2'd0, 32'd5, 32'h80, 1'b1, "s5xmin");
        run_op(2'd1, 32'h8, 32'h7, 1'b1, "w4_m8x7");
        run_op(2'd2, 32'hFFFF, 32'h2, 1'b0, "w16_u");
        for (int i = 0; i < 20; i++)
            run_op(2'($urandom_range(0, 2)), $urandom, $urandom, 1'($urandom), "rand");
        // abort in the 4th RUN cycle
        sel = 2'd0; mcand = 32'h33; mplier = 32'h21; smode = 1'b0; start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge Clk); #1;
        end
        Reset_n = 1'b0;
        #1;
        check("abort_state", {45'd0, b8, d8, p8}, 64'd0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge Clk); #1;
            if (d8 || b8) seen++;
        end
        check("abort_quiet", 64'(seen), 64'd0);
        run_op(2'd0, 32'd3, 32'd5, 1'b0, "post_rst");
        // Start held high, operands changing every cycle
        sel = 2'd0;
        start = 1'b1;
        last_done = -1;
        for (int e = 0; e < 30; e++) begin
            mcand = $urandom; mplier = $urandom; smode = 1'($urandom);
            if (e % 10 == 0) q.push_back(ref_prod(mcand, mplier, smode, 8));
            if (e == 29) start = 1'b0;
            @(posedge Clk); #1;
            check("b2b_done", 64'(d8), 64'(e % 10 == 8));
            if (d8) begin
                exp = q.size() > 0 ? q.pop_front() : 64'hDEAD;
                check("b2b_prod", 64'(p8), exp);
                if (last_done >= 0) check("b2b_gap", 64'(e - last_done), 64'd10);
                last_done = e;
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
